fetch_unit: RTL and testbench

Instruction-fetch stage of the pipeline, the producer end of the IF/ID interface. It owns the program counter and fetches one instruction at a time over a request/grant/response instruction-memory port. It buffers each returned word and presents it as f_instr / f_pc / f_pc4 to the IF/ID pipeline register. It stalls with the IF/ID enable and squashes in-flight fetches on a branch/jump redirect from a later stage.

---
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one fetch at a time over a
// req/gnt/rvalid port and buffers the returned word for the IF/ID register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_id_enable,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] f_instr,
    output logic [31:0] f_pc,
    output logic [31:0] f_pc4,
    output logic        f_valid
);

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] BOOT_PC    = RESET_PC & ALIGN_MASK;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] req_pc;
    logic [31:0] ibuf_instr;
    logic [31:0] ibuf_pc;
    logic        ibuf_valid;
    logic        fire;
    logic [31:0] redirect_target;

    // Only request when the buffer will be free by the time the response lands.
    assign imem_req        = reset_n & (state_q == S_REQ) & (~ibuf_valid | if_id_enable);
    assign imem_addr       = pc_q;
    assign fire            = imem_req & imem_gnt;
    assign redirect_target = redirect_pc & ALIGN_MASK;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_REQ;
            pc_q       <= BOOT_PC;
            req_pc     <= 32'h0;
            ibuf_instr <= 32'h0;
            ibuf_pc    <= 32'h0;
            ibuf_valid <= 1'b0;
        end else begin
            if (ibuf_valid && if_id_enable) begin
                ibuf_valid <= 1'b0;
            end

            case (state_q)
                S_REQ: begin
                    if (fire) begin
                        if (redirect) begin
                            state_q <= S_DRAIN;
                        end else begin
                            req_pc  <= pc_q;
                            pc_q    <= pc_q + 32'd4;
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_q <= S_REQ;
                        if (!redirect) begin
                            ibuf_instr <= imem_rdata;
                            ibuf_pc    <= req_pc;
                            ibuf_valid <= 1'b1;
                        end
                    end else if (redirect) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase

            // Redirect wins over every other PC update and kills the wrong-path word.
            if (redirect) begin
                pc_q       <= redirect_target;
                ibuf_valid <= 1'b0;
            end
        end
    end

    assign f_valid = ibuf_valid;
    assign f_instr = ibuf_valid ? ibuf_instr : NOP_INSTR;
    assign f_pc    = ibuf_pc;
    assign f_pc4   = ibuf_pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected fetches go into a queue, a monitor
// pops and compares on every IF/ID capture.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset_n;
    logic        if_id_enable;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] f_instr;
    logic [31:0] f_pc;
    logic [31:0] f_pc4;
    logic        f_valid;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    fetch_unit #(
        .RESET_PC (32'h0000_0100),
        .NOP_INSTR(NOP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .if_id_enable(if_id_enable),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .f_instr     (f_instr),
        .f_pc        (f_pc),
        .f_pc4       (f_pc4),
        .f_valid     (f_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Address-tagged instruction word returned by the memory model.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory: grant controlled by gnt_en, response `lat` cycles after grant.
    logic        gnt_en;
    int          lat;
    logic        mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;

    assign imem_gnt    = gnt_en;
    assign imem_rvalid = mem_pend && (mem_cnt == 1);
    assign imem_rdata  = imem_rvalid ? word_of(mem_addr) : 32'hDEAD_BEEF;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_pend <= 1'b0;
            mem_cnt  <= 0;
            mem_addr <= 32'h0;
        end else if (imem_req && imem_gnt) begin
            mem_pend <= 1'b1;
            mem_cnt  <= lat;
            mem_addr <= imem_addr;
        end else if (mem_pend) begin
            if (mem_cnt == 1) mem_pend <= 1'b0;
            else mem_cnt <= mem_cnt - 1;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] pc4);
        exp_t e;
        e.pc  = pc;
        e.pc4 = pc4;
        exp_q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0:       return imem_req;
            1:       return f_valid;
            default: return imem_rvalid;
        endcase
    endfunction

    // Bounded wait for a DUT/memory signal; a timeout is a failed comparison.
    task automatic wait_for(input string nm, input int sel);
        int n = 0;
        while (probe(sel) !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        n_checks++;
        if (probe(sel) === 1'b1) n_pass++;
        else $display("FAIL %s: timed out after %0d cycles, required event never seen", nm, n);
    endtask

    // Monitor: every word IF/ID captures on a non-redirect cycle must be expected.
    always @(negedge clk) begin
        if (reset_n && f_valid && if_id_enable && !redirect) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_capture: got f_pc %h expected no capture", f_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("mon_f_pc", f_pc, mon_e.pc);
                check("mon_f_pc4", f_pc4, mon_e.pc4);
                check("mon_f_instr", f_instr, word_of(mon_e.pc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        if_id_enable = 1'b1;
        redirect     = 1'b0;
        redirect_pc  = 32'h0;
        gnt_en       = 1'b1;
        lat          = 1;

        tick();
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_imem_addr", imem_addr, 32'h100);
        check("rst_f_valid", f_valid, 1'b0);
        check("rst_f_instr", f_instr, NOP);
        check("rst_f_pc", f_pc, 32'h0);
        check("rst_f_pc4", f_pc4, 32'h4);

        // Boot with a 1-cycle memory
        push(32'h100, 32'h104);
        push(32'h104, 32'h108);
        reset_n = 1'b1;
        #1;
        check("boot_req", imem_req, 1'b1);
        check("boot_addr", imem_addr, 32'h100);
        tick();
        check("boot_gap0_valid", f_valid, 1'b0);
        check("boot_wait_req", imem_req, 1'b0);
        tick();
        check("boot_v100", f_valid, 1'b1);
        tick();
        check("boot_gap1_valid", f_valid, 1'b0);
        check("boot_gap1_instr", f_instr, NOP);
        tick();

        // Stall with 0x104 buffered
        if_id_enable = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            check("stall_valid", f_valid, 1'b1);
            check("stall_pc", f_pc, 32'h104);
            check("stall_instr", f_instr, word_of(32'h104));
            check("stall_req", imem_req, 1'b0);
        end
        tick();
        if_id_enable = 1'b1;
        lat          = 3;
        #1;
        check("unstall_req", imem_req, 1'b1);
        check("unstall_addr", imem_addr, 32'h108);

        // Redirect one cycle after the grant of 0x108 (3-cycle memory)
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        #1;
        check("rdw_drain_req", imem_req, 1'b0);
        check("rdw_addr", imem_addr, 32'h200);
        check("rdw_valid", f_valid, 1'b0);
        push(32'h200, 32'h204);
        wait_for("rdw_wait_req", 0);
        check("rdw_req_addr", imem_addr, 32'h200);
        tick();
        gnt_en = 1'b0;
        lat    = 2;
        wait_for("rdw_wait_200", 1);

        // Redirect coinciding with a grant in REQ
        tick();
        check("rgnt_pre_valid", f_valid, 1'b0);
        check("rgnt_pre_req", imem_req, 1'b1);
        check("rgnt_pre_addr", imem_addr, 32'h204);
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        gnt_en      = 1'b1;
        tick();
        redirect = 1'b0;
        #1;
        check("rgnt_drain_req", imem_req, 1'b0);
        check("rgnt_addr", imem_addr, 32'h300);
        check("rgnt_valid", f_valid, 1'b0);
        push(32'h300, 32'h304);
        wait_for("rgnt_wait_req", 0);
        check("rgnt_req_addr", imem_addr, 32'h300);
        wait_for("rgnt_wait_300", 1);

        // Redirect coinciding with rvalid in WAIT
        wait_for("rrv_wait_rvalid", 2);
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        tick();
        redirect = 1'b0;
        #1;
        check("rrv_valid", f_valid, 1'b0);
        check("rrv_req", imem_req, 1'b1);
        check("rrv_addr", imem_addr, 32'h400);
        push(32'h400, 32'h404);
        wait_for("rrv_wait_400", 1);

        // Misaligned redirect to the top of memory, then wrap
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect = 1'b0;
        #1;
        check("wrap_drain_req", imem_req, 1'b0);
        check("wrap_addr_align", imem_addr, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC, 32'h0000_0000);
        wait_for("wrap_wait_req", 0);
        check("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
        wait_for("wrap_wait_top", 1);
        check("wrap_f_pc4", f_pc4, 32'h0);
        check("wrap_next_addr", imem_addr, 32'h0);
        check("wrap_next_req", imem_req, 1'b1);

        // Async reset while a word is presented and a request is up
        tick();
        wait_for("arst_wait_zero", 1);
        check("arst_pre_pc", f_pc, 32'h0);
        check("arst_pre_req", imem_req, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", f_valid, 1'b0);
        check("arst_req", imem_req, 1'b0);
        check("arst_addr", imem_addr, 32'h100);
        check("arst_instr", f_instr, NOP);
        tick();
        tick();
        push(32'h100, 32'h104);
        push(32'h104, 32'h108);
        reset_n = 1'b1;
        #1;
        check("reboot_req", imem_req, 1'b1);
        check("reboot_addr", imem_addr, 32'h100);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
        tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
